ei_axi_slave: RTL
=================

# ei_axi_slave

AXI3-style memory slave that sits directly downstream of `ei_axi_master` and terminates its AW/W/AR/R channels. It accepts write bursts into an internal word-addressed array and returns read bursts from it, so the master-side testbench has a real responder with burst addressing, backpressure and last-beat checking. No B channel exists in this interface. Write completion is implied by acceptance of the last W beat.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of AWADDR/ARADDR.
- `DATA_WIDTH`, 32: width of WDATA/RDATA. Must be a power of two ≥ 8.
- `MEM_DEPTH`, 256: number of DATA_WIDTH words. Must be a power of two.

Ports:
- `ACLK` in 1: clock, rising edge.
- `ARESETn` in 1: reset, asynchronous assert, active-low.
- `AWADDR` in ADDR_WIDTH: write burst start byte address.
- `AWLEN` in 4: beats − 1.
- `AWSIZE` in 3: bytes per beat = 2^AWSIZE.
- `AWBURST` in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR.
- `AWVALID` in 1 / `AWREADY` out 1: write address handshake.
- `WDATA` in DATA_WIDTH: write beat data.
- `WLAST` in 1: master's last-beat marker.
- `WVALID` in 1 / `WREADY` out 1: write data handshake.
- `ARADDR`, `ARLEN`, `ARSIZE`, `ARBURST` in: read counterparts of the AW fields.
- `ARVALID` in 1 / `ARREADY` out 1: read address handshake.
- `RDATA` out DATA_WIDTH: read beat data.
- `RLAST` out 1: final read beat.
- `RVALID` out 1 / `RREADY` in 1: read data handshake.
- `wlast_err` out 1: sticky flag, set on a WLAST/beat-count mismatch.

## Operation
- The write FSM and read FSM run independently and concurrently.
- Write FSM states:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch addr/len/size/burst, clear the beat counter, go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1 (see Configuration). Each WVALID&WREADY writes WDATA to the word at the current address and advances the address.
  - W_DATA exits to W_IDLE on the beat where count==len, or on a beat with WLAST=1, whichever comes first.
  - wlast_err is set when WLAST=1 before count==len, or when WLAST=0 on the beat where count==len.
- Read FSM states:
  - R_IDLE: ARREADY=1. On handshake, latch the AR fields and go to R_DATA.
  - R_DATA: RVALID=1, RDATA = mem[current word], RLAST=(count==len). On RVALID&RREADY, advance the address and count. After the RLAST beat, go to R_IDLE.
- Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH. Out-of-range addresses alias. Every write stores the full word; no strobes.
- Address update per beat, with step = 2^size:
  - FIXED: no change.
  - INCR: addr += step.
  - WRAP: boundary = (len+1)·step. addr = (addr & ~(boundary−1)) | ((addr+step) & (boundary−1)). Only len ∈ {1,3,7,15} is valid; any other len is treated as INCR.
- Write and read hitting the same word in the same cycle: the read returns the old data (read-first).
- Memory is not reset. Contents are preserved across ARESETn.

## Timing
- Reset values: AWREADY=0, ARREADY=0, WREADY=0, RVALID=0, RLAST=0, RDATA=0, wlast_err=0, both FSMs in IDLE. AWREADY and ARREADY go to 1 on the first clock edge after ARESETn deasserts.
- AW handshake at edge N: WREADY=1 from cycle N+1. A single-beat burst returns to W_IDLE at the edge of that beat, with AWREADY=1 in the next cycle.
- AR handshake at edge N: RVALID=1 with valid RDATA in cycle N+1.
- RVALID, RDATA and RLAST are held stable while RREADY=0. With RREADY held at 1, one beat is transferred per cycle.
- Back-to-back bursts have 1 idle cycle between the last beat and the next ADDR ready.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronously). The burst is abandoned, and words already written stay written.

## Configuration
- `EI_AXI_SLAVE_BACKPRESSURE_EN` defined:
  - An 8-bit Fibonacci LFSR (seed 8'hA5, taps 8,6,5,4) advances every cycle out of reset.
  - In W_DATA, WREADY = lfsr[0].
  - In R_DATA, entering the next beat is stalled while lfsr[1]==0. RVALID is not deasserted once asserted.
- Undefined: no stalls. WREADY=1 throughout W_DATA, and RVALID is continuous.

## Test plan
- Reset, then INCR write: AWADDR=0x10, AWLEN=3, AWSIZE=2, WDATA 0xA0..0xA3 with WLAST on beat 3. Then INCR read of the same burst. Required: RDATA 0xA0,0xA1,0xA2,0xA3, RLAST only on the 4th beat, wlast_err=0.
- WRAP read: ARADDR=0x18, ARLEN=3, ARSIZE=2, memory words 4..7 = 4,5,6,7. Required: RDATA 6,7,4,5 (addresses 0x18,0x1C,0x10,0x14).
- FIXED write: AWADDR=0x20, AWLEN=2, data 1,2,3. Then a single-beat read at 0x20. Required: RDATA=3.
- Early WLAST: AWLEN=3 with WLAST on beat 1. Required: two words written, WREADY=0 in the next cycle, wlast_err=1 and sticky until reset.
- RREADY held low for 5 cycles during beat 0 of a 2-beat read. Required: RVALID=1 and RDATA unchanged for all 5 cycles, then 2 beats complete with no beat lost.
- Reset mid-write after 2 of 4 beats. Required: WREADY=0 and AWREADY=0 immediately. After reset, AWREADY=1 one cycle after release, and the 2 written words read back correctly.

Source files
------------

// File: rtl/ei_axi_slave_if.sv
// AW/W/AR/R channel bundle between ei_axi_master and ei_axi_slave (no B channel).
interface ei_axi_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [3:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WLAST, WVALID,
        input  WREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WLAST, WVALID,
        output WREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/ei_axi_slave.sv
// AXI3-style burst memory slave with independent write and read FSMs over a word array.
// Define EI_AXI_SLAVE_BACKPRESSURE_EN to add LFSR-driven WREADY and read-beat stalls.
module ei_axi_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    ei_axi_slave_if.slave axi,
    output logic          wlast_err
);
    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
    localparam int MEM_AW  = $clog2(MEM_DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [MEM_AW-1:0]     idx_t;
    typedef enum logic { W_IDLE, W_DATA } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // High bits above the array depth are dropped, so out-of-range addresses alias.
    function automatic idx_t word_idx(input addr_t a);
        return idx_t'(a >> BYTE_SH);
    endfunction

    function automatic addr_t next_addr(input addr_t a, input logic [3:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        addr_t step;
        addr_t incr;
        addr_t mask;
        logic  wrap_ok;
        step    = addr_t'(1) << size;
        incr    = a + step;
        mask    = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = wrap_ok ? ((a & ~mask) | (incr & mask)) : incr;
            default: next_addr = incr;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic ready_q;
    logic w_allow;
    logic r_allow;

`ifdef EI_AXI_SLAVE_BACKPRESSURE_EN
    localparam bit STALL_EN = 1'b1;
    logic [7:0] lfsr_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign w_allow = lfsr_q[0];
    assign r_allow = lfsr_q[1];
`else
    localparam bit STALL_EN = 1'b0;
    assign w_allow = 1'b1;
    assign r_allow = 1'b1;
`endif

    // ------------------------------------------------------------------ write side
    w_state_t   w_state_q, w_state_d;
    addr_t      waddr_q, waddr_d;
    logic [3:0] wlen_q, wlen_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [2:0] wsize_q, wsize_d;
    logic [1:0] wburst_q, wburst_d;
    logic       err_q, err_d;
    logic       awready;
    logic       wready;
    logic       mem_we;
    idx_t       widx;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        err_d     = err_q;
        awready   = 1'b0;
        wready    = 1'b0;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready = ready_q;
                if (axi.AWVALID && ready_q) begin
                    waddr_d   = axi.AWADDR;
                    wlen_d    = axi.AWLEN;
                    wsize_d   = axi.AWSIZE;
                    wburst_d  = axi.AWBURST;
                    wcnt_d    = 4'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = w_allow;
                if (axi.WVALID && w_allow) begin
                    mem_we  = 1'b1;
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 4'd1;
                    // Either early WLAST or a missing WLAST on the final beat is an error.
                    if (axi.WLAST != (wcnt_q == wlen_q)) begin
                        err_d = 1'b1;
                    end
                    if (axi.WLAST || (wcnt_q == wlen_q)) begin
                        w_state_d = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign widx = word_idx(waddr_q);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ready_q   <= 1'b0;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            err_q     <= err_d;
        end
    end

    // Storage is deliberately outside the reset so contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[widx] <= axi.WDATA;
        end
    end

    // ------------------------------------------------------------------ read side
    r_state_t              r_state_q, r_state_d;
    addr_t                 raddr_q, raddr_d;
    logic [3:0]            rlen_q, rlen_d;
    logic [3:0]            rcnt_q, rcnt_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  arready;
    logic                  rd_load;
    idx_t                  ridx;

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rvalid_d  = rvalid_q;
        arready   = 1'b0;
        rd_load   = 1'b0;
        ridx      = word_idx(raddr_q);
        case (r_state_q)
            R_IDLE: begin
                arready = ready_q;
                if (axi.ARVALID && ready_q) begin
                    raddr_d   = axi.ARADDR;
                    rlen_d    = axi.ARLEN;
                    rsize_d   = axi.ARSIZE;
                    rburst_d  = axi.ARBURST;
                    rcnt_d    = 4'd0;
                    rd_load   = 1'b1;
                    ridx      = word_idx(axi.ARADDR);
                    rvalid_d  = !STALL_EN;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // A stalled beat only raises RVALID; once raised it stays until accepted.
                if (!rvalid_q && r_allow) begin
                    rvalid_d = 1'b1;
                end
                if (rvalid_q && axi.RREADY) begin
                    if (rcnt_q == rlen_q) begin
                        rvalid_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d  = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        rcnt_d   = rcnt_q + 4'd1;
                        rd_load  = 1'b1;
                        ridx     = word_idx(raddr_d);
                        rvalid_d = !STALL_EN;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Registered read: a same-cycle write to this word lands after the old value is sampled.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            rdata_q <= mem[ridx];
        end
    end

    assign axi.AWREADY = awready;
    assign axi.WREADY  = wready;
    assign axi.ARREADY = arready;
    assign axi.RVALID  = rvalid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RLAST   = rvalid_q && (rcnt_q == rlen_q);
    assign wlast_err   = err_q;
endmodule
